// File: rtl/lfsr_checker.sv
// PRBS checker for a 32-bit XNOR LFSR stream (taps 32, 22, 2, 1).
// Fills a shadow register from the stream, verifies 32 consecutive predictions,
// then free-runs (flywheels) on its own predictions while LOCKED, counting
// mismatches per window and dropping lock once a window sees too many.
module lfsr_checker #(
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             err_pulse,
  output logic             lol_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned WinW = $clog2(WINDOW);
  // Window error counter must be able to hold ERR_THRESH (up to WINDOW).
  localparam int unsigned WeW  = $clog2(WINDOW + 1);
  localparam logic [WeW-1:0] ThreshVal = WeW'(ERR_THRESH);

  typedef enum logic [1:0] {
    StFill,
    StVerify,
    StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [32:1]      shadow_q, shadow_d;
  logic [4:0]       fill_cnt_q, fill_cnt_d;
  logic [4:0]       match_cnt_q, match_cnt_d;
  logic [WinW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WeW-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lol_pulse_q, lol_pulse_d;
  logic             locked_q, locked_d;

  logic             pred;
  logic             mismatch;
  logic [32:1]      shift_in;
  logic [32:1]      shift_pred;
  logic [WinW-1:0]  bit_cnt_inc;
  logic [WeW-1:0]   win_err_inc;

  // Prediction of the next stream bit and the two candidate shadow updates.
  always_comb begin
    pred        = ~(shadow_q[32] ^ shadow_q[22] ^ shadow_q[2] ^ shadow_q[1]);
    mismatch    = (in_bit != pred);
    shift_in    = {shadow_q[31:1], in_bit};
    shift_pred  = {shadow_q[31:1], pred};
    bit_cnt_inc = bit_cnt_q + 1'b1;
    win_err_inc = win_err_q + 1'b1;
  end

  // Next-state logic: everything holds and pulses are low unless in_valid.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    lol_pulse_d = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StFill: begin
          shadow_d = shift_in;
          if (fill_cnt_q == 5'd31) begin
            fill_cnt_d = '0;
            // All-ones is the XNOR lockup state; keep filling past it.
            if (shift_in != '1) begin
              state_d     = StVerify;
              match_cnt_d = '0;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end

        StVerify: begin
          shadow_d = shift_in;
          if (!mismatch) begin
            if (match_cnt_q == 5'd31) begin
              state_d   = StLocked;
              bit_cnt_d = '0;
              win_err_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            state_d    = StFill;
            fill_cnt_d = '0;
          end
        end

        StLocked: begin
          // Flywheel: the shadow follows its own prediction, not the stream.
          shadow_d = shift_pred;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
          end
          // Threshold check takes precedence over a window wrap on the same bit.
          if (mismatch && (win_err_inc == ThreshVal)) begin
            lol_pulse_d = 1'b1;
            state_d     = StFill;
            fill_cnt_d  = '0;
            bit_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == '0) begin
              win_err_d = '0;
            end else if (mismatch) begin
              win_err_d = win_err_inc;
            end
          end
        end

        default: begin
          state_d    = StFill;
          fill_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFill;
      shadow_q    <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      bit_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      lol_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      lol_pulse_q <= lol_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign lol_pulse = lol_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock acquisition, single errors, loss of
// lock, window boundary, stuck-at-1 input, sparse in_valid and async reset.
module tb_lfsr_checker;

  localparam int unsigned CntW = 16;
  localparam logic [32:1] Seed = 32'hABCC6EFE;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_bit;
  logic            locked;
  logic            err_pulse;
  logic            lol_pulse;
  logic [CntW-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  // Reference generator and pulse observation counters.
  logic [32:1] gen;
  int seen_err;
  int seen_lol;
  int seen_lock;
  int seen_unlock;
  int nvalid;
  int cyc;

  lfsr_checker #(
    .ERR_THRESH(8),
    .WINDOW    (256),
    .CNT_W     (CntW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .locked   (locked),
    .err_pulse(err_pulse),
    .lol_pulse(lol_pulse),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, observe 1 time unit later.
  task automatic send(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    if (err_pulse === 1'b1) seen_err++;
    if (lol_pulse === 1'b1) seen_lol++;
    if (locked === 1'b1) seen_lock++;
    else seen_unlock++;
  endtask

  // Advance the generator one step and send its bit, optionally inverted.
  task automatic send_gen(input logic invert);
    logic b;
    b   = ~(gen[32] ^ gen[22] ^ gen[2] ^ gen[1]);
    gen = {gen[31:1], b};
    send(1'b1, b ^ invert);
  endtask

  task automatic good_bits(input int n);
    for (int i = 0; i < n; i++) send_gen(1'b0);
  endtask

  task automatic clear_seen();
    seen_err    = 0;
    seen_lol    = 0;
    seen_lock   = 0;
    seen_unlock = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    gen     = Seed;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    gen      = Seed;
    clear_seen();
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_lol_pulse", 32'(lol_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;

    // Lock after exactly 64 valid bits, then a long clean run.
    good_bits(63);
    check("lock_not_yet_63", 32'(locked), 32'd0);
    good_bits(1);
    check("lock_at_64", 32'(locked), 32'd1);
    clear_seen();
    good_bits(10000);
    check("clean_err_pulses", 32'(seen_err), 32'd0);
    check("clean_unlocked_cycles", 32'(seen_unlock), 32'd0);
    check("clean_err_count", 32'(err_count), 32'd0);

    // Single inverted bit, 100th after the clean run.
    good_bits(99);
    send_gen(1'b1);
    check("single_err_pulse", 32'(err_pulse), 32'd1);
    check("single_err_count", 32'(err_count), 32'd1);
    check("single_locked", 32'(locked), 32'd1);
    send_gen(1'b0);
    check("single_pulse_one_cycle", 32'(err_pulse), 32'd0);
    clear_seen();
    good_bits(300);
    check("single_no_more_errs", 32'(seen_err), 32'd0);
    check("single_still_locked", 32'(seen_unlock), 32'd0);
    check("single_count_held", 32'(err_count), 32'd1);

    // Eight errors inside the first window after lock -> loss of lock.
    do_reset();
    good_bits(64);
    check("lol_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 8; i++) begin
      good_bits(3);
      send_gen(1'b1);
      check($sformatf("lol_err_pulse_%0d", i), 32'(err_pulse), 32'd1);
      check($sformatf("lol_pulse_%0d", i), 32'(lol_pulse), (i == 7) ? 32'd1 : 32'd0);
    end
    check("lol_unlocked", 32'(locked), 32'd0);
    check("lol_err_count", 32'(err_count), 32'd8);
    good_bits(1);
    check("lol_pulse_one_cycle", 32'(lol_pulse), 32'd0);
    good_bits(62);
    check("relock_not_yet", 32'(locked), 32'd0);
    good_bits(1);
    check("relock_at_64", 32'(locked), 32'd1);

    // Seven errors at the end of window 0 and seven at the start of window 1.
    do_reset();
    good_bits(64);
    clear_seen();
    good_bits(248);
    for (int i = 0; i < 7; i++) send_gen(1'b1);   // k = 248..254
    good_bits(1);                                  // k = 255, window wraps
    for (int i = 0; i < 7; i++) send_gen(1'b1);   // k = 256..262
    good_bits(40);
    check("win_err_pulses", 32'(seen_err), 32'd14);
    check("win_no_lol", 32'(seen_lol), 32'd0);
    check("win_stay_locked", 32'(seen_unlock), 32'd0);
    check("win_err_count", 32'(err_count), 32'd14);

    // Stuck-at-1 input is the lockup pattern and must never lock.
    do_reset();
    clear_seen();
    for (int i = 0; i < 200; i++) send(1'b1, 1'b1);
    check("stuck1_never_locked", 32'(seen_lock), 32'd0);
    check("stuck1_err_count", 32'(err_count), 32'd0);

    // 30% in_valid duty; idle cycles carry junk on in_bit.
    do_reset();
    clear_seen();
    nvalid = 0;
    cyc    = 0;
    while (nvalid < 63 && cyc < 5000) begin
      if ($urandom_range(0, 99) < 30) begin
        send_gen(1'b0);
        nvalid++;
      end else begin
        send(1'b0, 1'($urandom));
      end
      cyc++;
    end
    check("duty_63_valid_reached", 32'(nvalid), 32'd63);
    check("duty_not_locked_63", 32'(seen_lock), 32'd0);
    cyc = 0;
    while (nvalid < 64 && cyc < 5000) begin
      if ($urandom_range(0, 99) < 30) begin
        send_gen(1'b0);
        nvalid++;
      end else begin
        send(1'b0, 1'($urandom));
        check("duty_idle_locked", 32'(locked), 32'd0);
      end
      cyc++;
    end
    check("duty_locked_64", 32'(locked), 32'd1);
    send(1'b0, 1'b1);
    check("duty_idle_hold_lock", 32'(locked), 32'd1);
    check("duty_idle_no_pulse", 32'(err_pulse), 32'd0);
    check("duty_err_pulses", 32'(seen_err), 32'd0);

    // Async reset mid-LOCKED with five accumulated errors.
    do_reset();
    good_bits(64);
    for (int i = 0; i < 5; i++) begin
      good_bits(10);
      send_gen(1'b1);
    end
    check("pre_rst_err_count", 32'(err_count), 32'd5);
    check("pre_rst_err_pulse", 32'(err_pulse), 32'd1);
    check("pre_rst_locked", 32'(locked), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_err_pulse", 32'(err_pulse), 32'd0);
    check("async_rst_lol_pulse", 32'(lol_pulse), 32'd0);
    check("async_rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    gen     = Seed;
    good_bits(63);
    check("post_rst_not_yet", 32'(locked), 32'd0);
    good_bits(1);
    check("post_rst_relock", 32'(locked), 32'd1);
    check("post_rst_err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
